// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic feeder
package systolic_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } feeder_state_e;

  // Zero-input advances needed after the last beat until every product has reached its PE.
  function automatic int flush_cycles(input int n_rows, input int n_cols, input int pipe_lat);
    return n_rows + n_cols - 2 + pipe_lat;
  endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - one INT8 lane delayed by DEPTH advances
module skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              adv,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, sclr, adv};
    assign dout = din;
  end else begin : g_shift
    logic [LANE_W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (sclr) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (adv) begin
        sr_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews tile K-slices into a systolic array and sequences clear/flush/done
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N_ROWS   = 2,
  parameter int N_COLS   = 2,
  parameter int KW       = 16,
  parameter int PIPE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KW-1:0]            tk,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [N_ROWS*LANE_W-1:0] s_a,
  input  logic [N_COLS*LANE_W-1:0] s_b,
  output logic [N_ROWS*LANE_W-1:0] a_in_flat,
  output logic [N_COLS*LANE_W-1:0] b_in_flat,
  output logic                     en,
  output logic                     clr,
  output logic                     busy,
  output logic                     done
);

  localparam int FLUSH_CYC = flush_cycles(N_ROWS, N_COLS, PIPE_LAT);
  localparam int FW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  feeder_state_e state_q, state_d;
  logic [KW-1:0] tk_q, tk_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          en_q, done_q;
  logic [N_ROWS*LANE_W-1:0] a_q, a_skew, a_feed;
  logic [N_COLS*LANE_W-1:0] b_q, b_skew, b_feed;
  logic accept, advance, sclr;

  assign s_ready = (state_q == ST_FEED);
  assign clr     = (state_q == ST_CLEAR);
  assign busy    = (state_q != ST_IDLE);
  assign accept  = s_valid & s_ready;
  assign advance = accept | (state_q == ST_FLUSH);
  assign sclr    = clr;
  assign a_feed  = s_ready ? s_a : '0;
  assign b_feed  = s_ready ? s_b : '0;

  for (genvar r = 0; r < N_ROWS; r++) begin : g_a
    skew_line #(.DEPTH(r)) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .sclr (sclr),
      .adv  (advance),
      .din  (a_feed[r*LANE_W +: LANE_W]),
      .dout (a_skew[r*LANE_W +: LANE_W])
    );
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_b
    skew_line #(.DEPTH(c)) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .sclr (sclr),
      .adv  (advance),
      .din  (b_feed[c*LANE_W +: LANE_W]),
      .dout (b_skew[c*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    state_d = state_q;
    tk_d    = tk_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    case (state_q)
      ST_IDLE: begin
        // done trails the DONE state by a cycle; a start alongside it still belongs to the old tile
        if (start && !done_q) begin
          tk_d    = tk;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        beat_d  = '0;
        flush_d = '0;
        state_d = (tk_q == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        if (accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_q == tk_q - KW'(1)) state_d = (FLUSH_CYC > 0) ? ST_FLUSH : ST_DONE;
        end
      end
      ST_FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FLUSH_LAST) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tk_q    <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      tk_q    <= tk_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      en_q    <= advance;
      done_q  <= (state_q == ST_DONE);
      if (advance) begin
        a_q <= a_skew;
        b_q <= b_skew;
      end
    end
  end

  assign en        = en_q;
  assign done      = done_q;
  assign a_in_flat = a_q;
  assign b_in_flat = b_q;

endmodule
